// File: rtl/mux_add_pipe.sv
// mux_add_pipe
//   Operand-select + add/sub datapath followed by an elastic pipeline of
//   STAGES register slots. Two operands are picked from a NUM_IN-wide operand
//   bus and either added or subtracted. The result, carry and signed-overflow
//   flag travel through the slots under valid/ready flow control, with a
//   synchronous flush that drops every in-flight entry.
//
//   Handshake: a beat transfers on any rising edge where valid && ready.
//   in_ready never depends on in_valid; it depends combinationally on
//   out_ready through the slot chain so a full pipe still takes a new beat
//   in the same cycle the oldest one leaves. While out_valid && !out_ready,
//   out_result/out_carry/out_ovf hold their values.
//
// Ports
//   clk         clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   flush       synchronous drop of all in-flight entries
//   in_valid    input beat valid
//   in_ready    pipe can accept a beat this cycle
//   in_data     operand bus, operand k = in_data[k*WIDTH +: WIDTH]
//   sel_a       index of operand A
//   sel_b       index of operand B
//   sub         0: A+B, 1: A-B
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   out_result  A+B or A-B modulo 2^WIDTH
//   out_carry   carry out of the MSB (for subtract: 1 = no borrow)
//   out_ovf     two's-complement signed overflow
module mux_add_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [$clog2(NUM_IN)-1:0] sel_a,
    input  logic [$clog2(NUM_IN)-1:0] sel_b,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_result,
    output logic                      out_carry,
    output logic                      out_ovf
);

    localparam int LAST = STAGES - 1;

    // ------------------------------------------------------------------
    // Operand select and add/sub
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ops [NUM_IN];
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic             new_ovf;

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            ops[k] = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign op_a   = ops[sel_a];
    assign op_b   = ops[sel_b];
    // Subtract as A + ~B + 1, so the carry out means "no borrow".
    assign addend = sub ? ~op_b : op_b;
    assign sum    = {1'b0, op_a} + {1'b0, addend} + {{WIDTH{1'b0}}, sub};
    // Overflow: both addends share a sign and the result's sign differs.
    assign new_ovf = (op_a[WIDTH-1] == addend[WIDTH-1]) &&
                     (sum[WIDTH-1] != op_a[WIDTH-1]);

    // ------------------------------------------------------------------
    // Slot chain
    // ------------------------------------------------------------------
    logic [STAGES-1:0] slot_valid;
    logic [WIDTH-1:0]  slot_result [STAGES];
    logic [STAGES-1:0] slot_carry;
    logic [STAGES-1:0] slot_ovf;

    logic [STAGES-1:0] free;   // slot can take a new entry this cycle
    logic [STAGES-1:0] drain;  // slot's entry moves downstream this cycle
    logic [STAGES-1:0] load;   // slot captures a new entry this cycle

    // free/drain ripple back from the output so a full pipe can still
    // advance as a whole in one cycle when out_ready is high.
    always_comb begin
        free        = '0;
        drain       = '0;
        drain[LAST] = slot_valid[LAST] && out_ready;
        free[LAST]  = !slot_valid[LAST] || out_ready;
        for (int i = LAST - 1; i >= 0; i--) begin
            drain[i] = slot_valid[i] && free[i+1];
            free[i]  = !slot_valid[i] || free[i+1];
        end
    end

    always_comb begin
        load    = '0;
        load[0] = in_valid && free[0];
        for (int i = 1; i < STAGES; i++) begin
            load[i] = drain[i-1];
        end
    end

    assign in_ready = free[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= '0;
            slot_carry <= '0;
            slot_ovf   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                slot_result[i] <= '0;
            end
        end else begin
            // A flushed cycle clears every valid bit, including any beat
            // loading into slot 0; data registers may keep stale values.
            for (int i = 0; i < STAGES; i++) begin
                if (flush) begin
                    slot_valid[i] <= 1'b0;
                end else begin
                    slot_valid[i] <= load[i] || (slot_valid[i] && !drain[i]);
                end
            end

            if (load[0]) begin
                slot_result[0] <= sum[WIDTH-1:0];
                slot_carry[0]  <= sum[WIDTH];
                slot_ovf[0]    <= new_ovf;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (load[i]) begin
                    slot_result[i] <= slot_result[i-1];
                    slot_carry[i]  <= slot_carry[i-1];
                    slot_ovf[i]    <= slot_ovf[i-1];
                end
            end
        end
    end

    assign out_valid  = slot_valid[LAST];
    assign out_result = slot_result[LAST];
    assign out_carry  = slot_carry[LAST];
    assign out_ovf    = slot_ovf[LAST];

endmodule

// File: tb/tb_mux_add_pipe.sv
// tb_mux_add_pipe
//   Scoreboard bench for mux_add_pipe. Accepted beats push the reference
//   model's result into exp_q; an output monitor pops and compares whenever
//   a result is consumed. Directed sections cover reset, latency, arithmetic
//   corner cases, backpressure, flush and asynchronous reset; a randomized
//   section mixes valid, ready and flush.
module tb_mux_add_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int STAGES = 2;
    localparam int SEL_W  = $clog2(NUM_IN);
    localparam int W      = WIDTH + 2;   // {ovf, carry, result}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel_a;
    logic [SEL_W-1:0]        sel_b;
    logic                    sub;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_result;
    logic                    out_carry;
    logic                    out_ovf;

    logic [WIDTH-1:0] ops [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_pack
        assign in_data[g*WIDTH +: WIDTH] = ops[g];
    end

    mux_add_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .STAGES(STAGES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .sub        (sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int accepted = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the selected operands.
    function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic s);
        longint sa, sb, r, maxv, minv;
        logic [WIDTH-1:0] res;
        logic c, o;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxv = (longint'(1) <<< (WIDTH - 1)) - 1;
        minv = -(longint'(1) <<< (WIDTH - 1));
        if (s) begin
            res = a - b;
            c   = (a >= b);
            r   = sa - sb;
        end else begin
            res = a + b;
            c   = ((longint'(a) + longint'(b)) >= (longint'(1) <<< WIDTH));
            r   = sa + sb;
        end
        o = (r > maxv) || (r < minv);
        return {o, c, res};
    endfunction

    // ---------------- input monitor: push expectations ----------------
    always @(negedge clk) begin
        if (reset_n && in_valid && in_ready) begin
            accepted++;
            if (!flush) exp_q.push_back(model(ops[sel_a], ops[sel_b], sub));
        end
    end

    // ---------------- output monitor: pop and compare ----------------
    logic         stall;
    logic [W-1:0] held;
    initial stall = 1'b0;

    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            stall = 1'b0;
        end else begin
            if (stall && out_valid)
                check("stall_hold", {out_ovf, out_carry, out_result}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0h expected none", out_result);
                end else begin
                    check("scoreboard", {out_ovf, out_carry, out_result}, exp_q.pop_front());
                end
            end
            stall = out_valid && !out_ready && !flush;
            held  = {out_ovf, out_carry, out_result};
            if (flush) exp_q.delete();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe with out_ready high: checks latency and value.
    task automatic one_beat(input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sb,
                            input logic s, input logic [WIDTH-1:0] er,
                            input logic ec, input logic eo);
        check("beat_in_ready", in_ready, 1);
        sel_a = sa; sel_b = sb; sub = s;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            check("lat_early", out_valid, 0);
            step();
        end
        check("lat_valid", out_valid, 1);
        check("beat_result", out_result, er);
        check("beat_carry", out_carry, ec);
        check("beat_ovf", out_ovf, eo);
        step();
    endtask

    task automatic drain_wait(input int budget);
        int n = 0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a0;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel_a = '0; sel_b = '0; sub = 1'b0;
        for (int k = 0; k < NUM_IN; k++) ops[k] = '0;

        // Reset
        repeat (3) step();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_result", out_result, 0);
        check("reset_out_carry", out_carry, 0);
        check("reset_out_ovf", out_ovf, 0);
        reset_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);
        step();

        // Add: operands 10,20,30,40 at indices 0..3, A=20, B=30
        ops[0] = 10; ops[1] = 20; ops[2] = 30; ops[3] = 40;
        one_beat(1, 2, 1'b0, 50, 1'b0, 1'b0);

        // Subtract with borrow, signed overflow, same-operand select
        ops[0] = 32'h0000_0005; ops[1] = 32'h0000_0007;
        one_beat(0, 1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        ops[0] = 32'h7FFF_FFFF; ops[1] = 32'h0000_0001;
        one_beat(0, 1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        ops[2] = 32'h0000_0003;
        one_beat(2, 2, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        ops[3] = 32'h8000_0000;
        one_beat(3, 1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        ops[0] = 32'hFFFF_FFFF; ops[1] = 32'h0000_0001;
        one_beat(0, 1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

        // Backpressure: beats 1..5 with out_ready low
        out_ready = 1'b0;
        a0 = accepted;
        sel_a = 0; sel_b = 1; sub = 1'b0; ops[1] = 0;
        for (int k = 1; k <= 5; k++) begin
            ops[0] = k;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("bp_accepted", accepted - a0, STAGES);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            check("bp_no_gap", out_valid, 1);
            step();
        end
        check("bp_no_repeat", out_valid, 0);

        // Flush: fill, then flush with a beat presented and out_ready high
        out_ready = 1'b0;
        for (int k = 0; k <= STAGES; k++) begin
            ops[0] = 100 + k;
            in_valid = 1'b1;
            step();
        end
        ops[0] = 99;
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_q_empty", exp_q.size(), 0);
        ops[0] = 55; ops[1] = 0;
        one_beat(0, 1, 1'b0, 55, 1'b0, 1'b0);

        // Randomized mix of valid, ready, flush
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM_IN; k++) ops[k] = $urandom;
            sel_a     = SEL_W'($urandom_range(0, NUM_IN - 1));
            sel_b     = SEL_W'($urandom_range(0, NUM_IN - 1));
            sub       = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        drain_wait(50);

        // Asynchronous reset while a result is waiting at the output
        ops[0] = 32'h1234; ops[1] = 1; sel_a = 0; sel_b = 1; sub = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (STAGES) step();
        check("ar_pre_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_result", out_result, 0);
        check("ar_in_ready", in_ready, 1);
        exp_q.delete();
        step();
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        ops[0] = 32'hFFFF_FFF0; ops[1] = 32'h0000_0020;
        one_beat(0, 1, 1'b0, 32'h0000_0010, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        total++;
        bad++;
        $display("FAIL timeout: got no completion expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
